// File: rtl/synth_bus_pkg.sv
// synth_bus_pkg: shared types for the patch-parameter register bus arbiter
package synth_bus_pkg;
  typedef logic [3:0] sel_t;
  localparam sel_t SEL_OSC = 4'b0001;
  localparam sel_t SEL_COM = 4'b0010;
  localparam sel_t SEL_M1  = 4'b0100;
  localparam sel_t SEL_M2  = 4'b1000;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} arb_state_t;
  typedef enum logic {REQ_M, REQ_H} requester_t;
  function automatic logic sel_ok(input sel_t s);
    return (s != '0) && ((s & (s - 4'd1)) == '0);
  endfunction
endpackage

// File: rtl/param_bus_arbiter_if.sv
// param_bus_arbiter_if: requester handshakes plus the downstream parameter register port
interface param_bus_arbiter_if import synth_bus_pkg::*; #(
  parameter int ADR_W  = 7,
  parameter int DATA_W = 8
);
  logic              m_req, m_wr, m_lock, m_ack, m_err;
  logic [ADR_W-1:0]  m_adr;
  sel_t              m_sel;
  logic [DATA_W-1:0] m_wdata, m_rdata;
  logic              h_req, h_wr, h_ack, h_err;
  logic [ADR_W-1:0]  h_adr;
  sel_t              h_sel;
  logic [DATA_W-1:0] h_wdata, h_rdata;
  logic [ADR_W-1:0]  adr;
  logic              write, read, osc_sel, com_sel, m1_sel, m2_sel;
  logic [DATA_W-1:0] synth_data_in, synth_data_out;
  logic              sysex_data_patch_send, busy;
  modport master (
    input  m_req, m_wr, m_adr, m_sel, m_wdata, m_lock,
    input  h_req, h_wr, h_adr, h_sel, h_wdata, synth_data_out,
    output m_ack, m_err, m_rdata, h_ack, h_err, h_rdata,
    output adr, write, read, osc_sel, com_sel, m1_sel, m2_sel,
    output synth_data_in, sysex_data_patch_send, busy
  );
  modport slave (
    output m_req, m_wr, m_adr, m_sel, m_wdata, m_lock,
    output h_req, h_wr, h_adr, h_sel, h_wdata, synth_data_out,
    input  m_ack, m_err, m_rdata, h_ack, h_err, h_rdata,
    input  adr, write, read, osc_sel, com_sel, m1_sel, m2_sel,
    input  synth_data_in, sysex_data_patch_send, busy
  );
endinterface

// File: rtl/param_rr_pick.sv
// param_rr_pick: two-way round-robin pick with an M burst lock bounded by LOCK_MAX
module param_rr_pick import synth_bus_pkg::*; #(
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 5
) (
  input  logic             m_req_i,
  input  logic             h_req_i,
  input  logic             m_lock_i,
  input  requester_t       last_i,
  input  logic [CNT_W-1:0] cnt_i,
  output requester_t       gnt_o,
  output logic             lock_hit_o
);
  always_comb begin
    lock_hit_o = m_req_i && h_req_i && m_lock_i && last_i == REQ_M && cnt_i < CNT_W'(LOCK_MAX);
    gnt_o      = !h_req_i ? REQ_M
               : !m_req_i ? REQ_H
               : lock_hit_o ? REQ_M
               : last_i == REQ_M ? REQ_H : REQ_M;
  end
endmodule

// File: rtl/param_bus_arbiter.sv
// param_bus_arbiter: shares the patch-parameter register port between the MIDI/sysex and host requesters
module param_bus_arbiter import synth_bus_pkg::*; #(
  parameter int ADR_W    = 7,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 16
) (
  input  logic                data_clk,
  input  logic                reset_data_N,
  param_bus_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  arb_state_t        state_q, state_d;
  requester_t        gnt_q, gnt_d, pick;
  logic              arb, lock_hit, in_iss, in_ack;
  logic              wr_q, wr_d, lock_q, lock_d, err_q, err_d;
  logic [ADR_W-1:0]  adr_q, adr_d, badr_d;
  sel_t              sel_q, sel_d, bsel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, sdi_d, rdata_d;
  logic [CNT_W-1:0]  lcnt_q, lcnt_d;
  logic [2:0]        lat_q, lat_d;
  logic              write_d, read_d, m_ack_d, h_ack_d, send_d;
  param_rr_pick #(.LOCK_MAX(LOCK_MAX), .CNT_W(CNT_W)) u_pick (
    .m_req_i    (bus.m_req),
    .h_req_i    (bus.h_req),
    .m_lock_i   (bus.m_lock),
    .last_i     (gnt_q),
    .cnt_i      (lcnt_q),
    .gnt_o      (pick),
    .lock_hit_o (lock_hit)
  );
  assign arb = state_q == IDLE && (bus.m_req || bus.h_req);
  // gnt_q doubles as last_grant: it only changes when a new winner is latched
  always_comb begin
    gnt_d   = arb ? pick : gnt_q;
    lcnt_d  = arb ? (lock_hit ? lcnt_q + CNT_W'(1) : '0) : lcnt_q;
    wr_d    = arb ? (pick == REQ_M ? bus.m_wr : bus.h_wr) : wr_q;
    adr_d   = arb ? (pick == REQ_M ? bus.m_adr : bus.h_adr) : adr_q;
    sel_d   = arb ? (pick == REQ_M ? bus.m_sel : bus.h_sel) : sel_q;
    wdata_d = arb ? (pick == REQ_M ? bus.m_wdata : bus.h_wdata) : wdata_q;
    lock_d  = arb ? pick == REQ_M && bus.m_lock : lock_q;
    err_d   = arb ? !sel_ok(sel_d) : err_q;
    state_d = state_q == IDLE  ? (arb ? (err_d ? ACK : ISSUE) : IDLE)
            : state_q == ISSUE ? (wr_q ? ACK : WAIT)
            : state_q == WAIT  ? (lat_q == 3'd1 ? ACK : WAIT)
            : IDLE;
    lat_d   = state_q == ISSUE ? 3'(RD_LAT) : state_q == WAIT ? lat_q - 3'd1 : lat_q;
  end
  // outputs are decoded from the next state so every pin comes straight from a flop
  always_comb begin
    in_iss  = state_d == ISSUE;
    in_ack  = state_d == ACK;
    badr_d  = in_iss ? adr_d : '0;
    bsel_d  = in_iss ? sel_d : '0;
    write_d = in_iss && wr_d;
    read_d  = in_iss && !wr_d;
    sdi_d   = write_d ? wdata_d : '0;
    rdata_d = in_ack && state_q == WAIT ? bus.synth_data_out : '0;
    m_ack_d = in_ack && gnt_d == REQ_M;
    h_ack_d = in_ack && gnt_d == REQ_H;
    send_d  = state_d != IDLE && lock_d;
  end
  always_ff @(posedge data_clk or negedge reset_data_N) begin
    if (!reset_data_N) begin
      state_q                   <= IDLE;
      gnt_q                     <= REQ_H;
      lcnt_q                    <= '0;
      wr_q                      <= 1'b0;
      adr_q                     <= '0;
      sel_q                     <= '0;
      wdata_q                   <= '0;
      lock_q                    <= 1'b0;
      err_q                     <= 1'b0;
      lat_q                     <= '0;
      bus.adr                   <= '0;
      bus.write                 <= 1'b0;
      bus.read                  <= 1'b0;
      bus.osc_sel               <= 1'b0;
      bus.com_sel               <= 1'b0;
      bus.m1_sel                <= 1'b0;
      bus.m2_sel                <= 1'b0;
      bus.synth_data_in         <= '0;
      bus.m_ack                 <= 1'b0;
      bus.m_err                 <= 1'b0;
      bus.m_rdata               <= '0;
      bus.h_ack                 <= 1'b0;
      bus.h_err                 <= 1'b0;
      bus.h_rdata               <= '0;
      bus.sysex_data_patch_send <= 1'b0;
      bus.busy                  <= 1'b0;
    end else begin
      state_q                   <= state_d;
      gnt_q                     <= gnt_d;
      lcnt_q                    <= lcnt_d;
      wr_q                      <= wr_d;
      adr_q                     <= adr_d;
      sel_q                     <= sel_d;
      wdata_q                   <= wdata_d;
      lock_q                    <= lock_d;
      err_q                     <= err_d;
      lat_q                     <= lat_d;
      bus.adr                   <= badr_d;
      bus.write                 <= write_d;
      bus.read                  <= read_d;
      bus.osc_sel               <= |(bsel_d & SEL_OSC);
      bus.com_sel               <= |(bsel_d & SEL_COM);
      bus.m1_sel                <= |(bsel_d & SEL_M1);
      bus.m2_sel                <= |(bsel_d & SEL_M2);
      bus.synth_data_in         <= sdi_d;
      bus.m_ack                 <= m_ack_d;
      bus.m_err                 <= m_ack_d && err_d;
      bus.m_rdata               <= m_ack_d ? rdata_d : '0;
      bus.h_ack                 <= h_ack_d;
      bus.h_err                 <= h_ack_d && err_d;
      bus.h_rdata               <= h_ack_d ? rdata_d : '0;
      bus.sysex_data_patch_send <= send_d;
      bus.busy                  <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_param_bus_arbiter.sv
// tb_param_bus_arbiter: randomized check of the parameter bus arbiter against a transaction-level model
module tb_param_bus_arbiter;
  localparam int RD_LAT   = 3;
  localparam int LOCK_MAX = 4;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   last_m;
  int   lock_cnt;
  param_bus_arbiter_if #(.ADR_W(7), .DATA_W(8)) bus ();
  param_bus_arbiter #(.ADR_W(7), .DATA_W(8), .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)) dut (
    .data_clk     (clk),
    .reset_data_N (rst_n),
    .bus          (bus.master)
  );
  always #5 clk = ~clk;
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    last_m   = 1'b0;
    lock_cnt = 0;
  endtask
  function automatic logic [3:0] rsel();
    return $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
  endfunction
  task automatic raise_m();
    bus.m_req   = 1'b1;
    bus.m_wr    = 1'($urandom);
    bus.m_adr   = 7'($urandom);
    bus.m_sel   = rsel();
    bus.m_wdata = 8'($urandom);
  endtask
  task automatic raise_h();
    bus.h_req   = 1'b1;
    bus.h_wr    = 1'($urandom);
    bus.h_adr   = 7'($urandom);
    bus.h_sel   = rsel();
    bus.h_wdata = 8'($urandom);
  endtask
  // Entered just after the edge that starts an IDLE cycle with requests applied; returns the
  // same way one cycle after the ack, with the winner's request withdrawn.
  task automatic do_txn(input logic [7:0] rdv, output bit got_m);
    bit         won_m, wr, lk, legal, iss, fin;
    logic [6:0] a;
    logic [3:0] s;
    logic [7:0] wd;
    int         ack_at;
    got_m = 1'b0;
    if (bus.m_req && bus.h_req) begin
      if (bus.m_lock && last_m && lock_cnt < LOCK_MAX) begin
        won_m = 1'b1;
        lock_cnt++;
      end else begin
        won_m    = !last_m;
        lock_cnt = 0;
      end
    end else begin
      won_m    = bus.m_req;
      lock_cnt = 0;
    end
    last_m = won_m;
    wr     = won_m ? bus.m_wr : bus.h_wr;
    a      = won_m ? bus.m_adr : bus.h_adr;
    s      = won_m ? bus.m_sel : bus.h_sel;
    wd     = won_m ? bus.m_wdata : bus.h_wdata;
    lk     = won_m && bus.m_lock;
    legal  = $countones(s) == 1;
    ack_at = !legal ? 1 : wr ? 2 : 2 + RD_LAT;
    for (int k = 0; k <= ack_at; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      bus.synth_data_out = (k == 1 + RD_LAT) ? rdv : ~rdv;
      @(negedge clk);
      iss = k == 1 && legal;
      fin = k == ack_at;
      if (fin) got_m = bus.m_ack;
      chk("busy", 32'(bus.busy), 32'(k > 0));
      chk("write", 32'(bus.write), 32'(iss && wr));
      chk("read", 32'(bus.read), 32'(iss && !wr));
      chk("adr", 32'(bus.adr), 32'(iss ? a : 7'h00));
      chk("sel", 32'({bus.m2_sel, bus.m1_sel, bus.com_sel, bus.osc_sel}), 32'(iss ? s : 4'h0));
      chk("synth_data_in", 32'(bus.synth_data_in), 32'(iss && wr ? wd : 8'h00));
      chk("m_ack", 32'(bus.m_ack), 32'(fin && won_m));
      chk("h_ack", 32'(bus.h_ack), 32'(fin && !won_m));
      chk("m_err", 32'(bus.m_err), 32'(fin && won_m && !legal));
      chk("h_err", 32'(bus.h_err), 32'(fin && !won_m && !legal));
      chk("m_rdata", 32'(bus.m_rdata), 32'(fin && won_m && legal && !wr ? rdv : 8'h00));
      chk("h_rdata", 32'(bus.h_rdata), 32'(fin && !won_m && legal && !wr ? rdv : 8'h00));
      chk("patch_send", 32'(bus.sysex_data_patch_send), 32'(k > 0 && lk));
    end
    @(posedge clk);
    #1;
    if (won_m) bus.m_req = 1'b0;
    else bus.h_req = 1'b0;
  endtask
  initial begin
    bit         gm;
    logic [5:0] lock_seq;
    logic [3:0] alt_seq;
    {bus.m_req, bus.m_wr, bus.m_lock, bus.h_req, bus.h_wr} = '0;
    {bus.m_adr, bus.h_adr, bus.m_sel, bus.h_sel} = '0;
    {bus.m_wdata, bus.h_wdata, bus.synth_data_out} = '0;
    model_reset();
    bus.m_req   = 1'b1;
    bus.m_wr    = 1'b1;
    bus.m_adr   = 7'h12;
    bus.m_sel   = 4'b0001;
    bus.m_wdata = 8'h5A;
    repeat (3) begin
      @(negedge clk);
      chk("rst_write", 32'(bus.write), 32'd0);
      chk("rst_read", 32'(bus.read), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_m_ack", 32'(bus.m_ack), 32'd0);
      chk("rst_adr", 32'(bus.adr), 32'd0);
      chk("rst_osc_sel", 32'(bus.osc_sel), 32'd0);
      chk("rst_sdi", 32'(bus.synth_data_in), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    do_txn(8'h00, gm);
    bus.h_req   = 1'b1;
    bus.h_wr    = 1'b0;
    bus.h_adr   = 7'h33;
    bus.h_sel   = 4'b0010;
    bus.h_wdata = 8'hEE;
    do_txn(8'hC3, gm);
    bus.m_req   = 1'b1;
    bus.m_wr    = 1'b1;
    bus.m_adr   = 7'h05;
    bus.m_sel   = 4'b0011;
    bus.m_wdata = 8'h77;
    do_txn(8'h00, gm);
    bus.m_lock = 1'b1;
    raise_m();
    raise_h();
    for (int i = 0; i < 6; i++) begin
      do_txn(8'($urandom), gm);
      lock_seq[i] = gm;
      if (!bus.m_req) raise_m();
      if (!bus.h_req) raise_h();
    end
    chk("lock_seq", 32'(lock_seq), 32'(6'b101111));
    bus.m_req  = 1'b0;
    bus.m_lock = 1'b0;
    bus.h_req  = 1'b1;
    bus.h_wr   = 1'b0;
    bus.h_adr  = 7'h40;
    bus.h_sel  = 4'b0100;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("wait_busy", 32'(bus.busy), 32'd1);
    chk("wait_read", 32'(bus.read), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    bus.h_req = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_h_ack", 32'(bus.h_ack), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
    repeat (8) begin
      @(negedge clk);
      chk("no_h_ack", 32'(bus.h_ack), 32'd0);
      chk("postrst_busy", 32'(bus.busy), 32'd0);
      @(posedge clk);
      #1;
    end
    raise_m();
    raise_h();
    for (int i = 0; i < 4; i++) begin
      do_txn(8'($urandom), gm);
      alt_seq[i] = gm;
      if (!bus.m_req) raise_m();
      if (!bus.h_req) raise_h();
    end
    chk("alt_seq", 32'(alt_seq), 32'(4'b0101));
    for (int i = 0; i < 300; i++) begin
      bus.m_lock = $urandom_range(0, 3) != 0;
      if (!bus.m_req && $urandom_range(0, 3) != 0) raise_m();
      if (!bus.h_req && $urandom_range(0, 3) != 0) raise_h();
      if (bus.m_req || bus.h_req) do_txn(8'($urandom), gm);
      else begin
        @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_strobe", 32'({bus.write, bus.read}), 32'd0);
        @(posedge clk);
        #1;
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
